// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// occupancy count, programmable almost-full/almost-empty and overflow/underflow pulses.
module sync_fifo_flex #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       wfull,
  output logic                       rempty,
  output logic                       walmost_full,
  output logic                       ralmost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C     = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C    = CW'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST_ADDR_C = AW'(DEPTH - 1);
  localparam logic          AFULL_RST_C = (AFULL_TH == 0);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wen;
  logic          ren;

  // Accept logic, pointer/count update and flag pre-decode from next count.
  always_comb begin
    wen         = winc & ~wfull_q;
    ren         = rinc & ~rempty_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    overflow_d  = winc & wfull_q;
    underflow_d = rinc & rempty_q;

    if (wen) begin
      waddr_d = (waddr_q == LAST_ADDR_C) ? '0 : waddr_q + AW'(1);
    end
    if (ren) begin
      raddr_d = (raddr_q == LAST_ADDR_C) ? '0 : raddr_q + AW'(1);
    end

    unique case ({wen, ren})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= AFULL_RST_C;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr_q] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown while non-empty; gated to zero so stale data never leaks.
      assign rvalid = ~rempty_q;
      assign rdata  = rempty_q ? '0 : mem_q[raddr_q];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = ren;
        if (ren) begin
          rdata_d = mem_q[raddr_q];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex: a DEPTH=5 standard-mode instance and a
// DEPTH=5 FWFT instance driven with directed vectors.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       winc_s, rinc_s, winc_f, rinc_f;
  logic [7:0] wdata_s, wdata_f, rdata_s, rdata_f;
  logic       rvalid_s, wfull_s, rempty_s, afull_s, aempty_s, ovf_s, udf_s;
  logic       rvalid_f, wfull_f, rempty_f, afull_f, aempty_f, ovf_f, udf_f;
  logic [2:0] count_s, count_f;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  logic [7:0] e_s, e_f;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .winc(winc_s), .wdata(wdata_s), .rinc(rinc_s),
    .rdata(rdata_s), .rvalid(rvalid_s), .wfull(wfull_s), .rempty(rempty_s),
    .walmost_full(afull_s), .ralmost_empty(aempty_s), .count(count_s),
    .overflow(ovf_s), .underflow(udf_s)
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .winc(winc_f), .wdata(wdata_f), .rinc(rinc_f),
    .rdata(rdata_f), .rvalid(rvalid_f), .wfull(wfull_f), .rempty(rempty_f),
    .walmost_full(afull_f), .ralmost_empty(aempty_f), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc_s(input logic w, input logic [7:0] d, input logic r);
    winc_s = w; wdata_s = d; rinc_s = r;
    @(posedge clk); #1;
    winc_s = 1'b0; rinc_s = 1'b0;
  endtask

  task automatic cyc_f(input logic w, input logic [7:0] d, input logic r);
    winc_f = w; wdata_f = d; rinc_f = r;
    @(posedge clk); #1;
    winc_f = 1'b0; rinc_f = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data.
  always @(negedge clk) begin
    if (rvalid_s) begin
      if (exp_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL std_unexpected_rvalid: actual rdata=%0h required=no output", rdata_s);
      end else begin
        e_s = exp_s.pop_front();
        chk("std_rdata", 32'(rdata_s), 32'(e_s));
      end
    end
    if (rvalid_f && rinc_f) begin
      if (exp_f.size() == 0) begin
        checks++; errors++;
        $display("FAIL fwft_unexpected_pop: actual rdata=%0h required=no pop", rdata_f);
      end else begin
        e_f = exp_f.pop_front();
        chk("fwft_rdata", 32'(rdata_f), 32'(e_f));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_state();
    chk("rst_count", 32'(count_s), 32'd0);
    chk("rst_rempty", 32'(rempty_s), 32'd1);
    chk("rst_wfull", 32'(wfull_s), 32'd0);
    chk("rst_afull", 32'(afull_s), 32'd0);
    chk("rst_aempty", 32'(aempty_s), 32'd1);
    chk("rst_rvalid", 32'(rvalid_s), 32'd0);
    chk("rst_rdata", 32'(rdata_s), 32'd0);
    chk("rst_ovf", 32'(ovf_s), 32'd0);
    chk("rst_udf", 32'(udf_s), 32'd0);
  endtask

  initial begin
    winc_s = 0; rinc_s = 0; wdata_s = 0;
    winc_f = 0; rinc_f = 0; wdata_f = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_state();
    chk("fwft_rst_rvalid", 32'(rvalid_f), 32'd0);
    chk("fwft_rst_rdata", 32'(rdata_f), 32'd0);

    // Fill 0x11..0x15: flags by hand (AFULL_TH=3, AEMPTY_TH=2, DEPTH=5).
    for (int i = 0; i < 5; i++) begin
      cyc_s(1'b1, 8'(8'h11 + i), 1'b0);
      chk("fill_count", 32'(count_s), 32'(i + 1));
      chk("fill_afull", 32'(afull_s), (i + 1 >= 3) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(aempty_s), (i + 1 <= 2) ? 32'd1 : 32'd0);
      chk("fill_wfull", 32'(wfull_s), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_s.push_back(8'(8'h11 + i));
      cyc_s(1'b0, 8'h00, 1'b1);
    end
    cyc_s(1'b0, 8'h00, 1'b0);
    chk("drain_count", 32'(count_s), 32'd0);
    chk("drain_rempty", 32'(rempty_s), 32'd1);

    // Wrap: offset pointers by 3, then a full pass crosses 4->0.
    for (int i = 0; i < 3; i++) cyc_s(1'b1, 8'(8'h01 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_s.push_back(8'(8'h01 + i));
      cyc_s(1'b0, 8'h00, 1'b1);
    end
    for (int i = 0; i < 5; i++) cyc_s(1'b1, 8'(8'hA0 + i), 1'b0);
    chk("wrap_full", 32'(wfull_s), 32'd1);
    for (int i = 0; i < 5; i++) begin
      exp_s.push_back(8'(8'hA0 + i));
      cyc_s(1'b0, 8'h00, 1'b1);
    end
    cyc_s(1'b0, 8'h00, 1'b0);
    chk("wrap_count", 32'(count_s), 32'd0);

    // Full boundary with simultaneous read: 0xEE must be dropped.
    for (int i = 0; i < 5; i++) cyc_s(1'b1, 8'(8'hB0 + i), 1'b0);
    exp_s.push_back(8'hB0);
    cyc_s(1'b1, 8'hEE, 1'b1);
    chk("ovf_count", 32'(count_s), 32'd4);
    chk("ovf_pulse", 32'(ovf_s), 32'd1);
    chk("ovf_wfull", 32'(wfull_s), 32'd0);
    cyc_s(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(ovf_s), 32'd0);
    for (int i = 1; i < 5; i++) begin
      exp_s.push_back(8'(8'hB0 + i));
      cyc_s(1'b0, 8'h00, 1'b1);
    end
    cyc_s(1'b0, 8'h00, 1'b0);
    chk("ovf_drain_rempty", 32'(rempty_s), 32'd1);

    // Empty boundary with simultaneous write.
    cyc_s(1'b1, 8'h3C, 1'b1);
    chk("udf_pulse", 32'(udf_s), 32'd1);
    chk("udf_count", 32'(count_s), 32'd1);
    chk("udf_rvalid", 32'(rvalid_s), 32'd0);
    exp_s.push_back(8'h3C);
    cyc_s(1'b0, 8'h00, 1'b1);
    chk("udf_clear", 32'(udf_s), 32'd0);
    cyc_s(1'b0, 8'h00, 1'b0);

    // Reset mid-stream at count 3.
    for (int i = 0; i < 3; i++) cyc_s(1'b1, 8'(8'h61 + i), 1'b0);
    chk("mid_count", 32'(count_s), 32'd3);
    rst_n = 1'b0;
    #2;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc_s(1'b1, 8'h77, 1'b0);
    exp_s.push_back(8'h77);
    cyc_s(1'b0, 8'h00, 1'b1);
    cyc_s(1'b0, 8'h00, 1'b0);
    chk("post_rst_count", 32'(count_s), 32'd0);

    // FWFT: written word appears next cycle without a read.
    cyc_f(1'b1, 8'h5A, 1'b0);
    chk("fwft_rvalid", 32'(rvalid_f), 32'd1);
    chk("fwft_rdata_show", 32'(rdata_f), 32'h5A);
    chk("fwft_count1", 32'(count_f), 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_f.push_back(8'(8'h5A + i));
      cyc_f(1'b1, 8'(8'h5B + i), 1'b1);
      chk("fwft_steady_count", 32'(count_f), 32'd1);
    end
    exp_f.push_back(8'h5E);
    cyc_f(1'b0, 8'h00, 1'b1);
    chk("fwft_end_count", 32'(count_f), 32'd0);
    chk("fwft_end_rvalid", 32'(rvalid_f), 32'd0);
    chk("fwft_end_rdata", 32'(rdata_f), 32'd0);

    repeat (2) cyc_s(1'b0, 8'h00, 1'b0);
    chk("std_sb_empty", 32'(exp_s.size()), 32'd0);
    chk("fwft_sb_empty", 32'(exp_f.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
